// File: rtl/divide.sv
// rtl/divide.sv - sequential 16-by-8 unsigned restoring divider, one quotient bit per clock
module divide (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        ready,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] q_q, q_d;        // dividend shifts out the top, quotient bits shift in the bottom
  logic [8:0]  r_q, r_d;        // partial remainder
  logic [7:0]  d_q, d_d;        // captured divisor
  logic [3:0]  cnt_q, cnt_d;    // iteration index 0..15
  logic [15:0] quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;

  // Trial value for this iteration: remainder shifted left with the next dividend bit.
  // Kept one bit wider than R so the compare never truncates.
  logic [9:0]  trial;
  logic        qbit;

  // State and datapath registers; reset clears everything and abandons any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath: load on start, one restoring step per RUN cycle
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    trial   = {r_q, q_q[15]};
    qbit    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor != 8'd0) begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            // Divide by zero resolves immediately with a saturated quotient
            quot_d  = 16'hFFFF;
            rem_d   = dividend[7:0];
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (trial >= {2'b00, d_q}) begin
          r_d  = trial[8:0] - {1'b0, d_q};
          qbit = 1'b1;
        end else begin
          r_d  = trial[8:0];
        end
        q_d   = {q_q[14:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          quot_d  = {q_q[14:0], qbit};
          rem_d   = r_d[7:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign ready       = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign div_by_zero = dbz_q;

endmodule

// File: doc/divide.md
# divide

Sequential 16-by-8 unsigned restoring divider; the inverse companion to the 8x8 shift-add `multiply` block. Accepts a 16-bit dividend and 8-bit divisor on a `start` pulse and produces one quotient bit per clock, MSB first, over 16 iterations. It delivers a 16-bit quotient and 8-bit remainder with a level `ready` flag. It sits beside `multiply` in the arithmetic datapath, so a product from `multiply` can be fed back as the dividend.

## Interface
- Parameters: none. Widths are fixed at 16-bit dividend/quotient and 8-bit divisor/remainder.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`; overrides all other inputs.
- `start`  in  1  load request; sampled on posedge `clk` in IDLE or DONE only.
- `dividend`  in  16  unsigned dividend; captured when `start` is accepted.
- `divisor`  in  8  unsigned divisor; captured when `start` is accepted.
- `quot`  out  16  registered quotient.
- `rem`  out  8  registered remainder.
- `ready`  out  1  high while in DONE; results are valid.
- `busy`  out  1  high while in RUN.
- `div_by_zero`  out  1  high in DONE when the captured divisor was 0.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - Q: 16-bit dividend/quotient shift register.
  - R: 9-bit partial remainder.
  - D: 8-bit divisor.
  - cnt: 4-bit iteration counter.
- `reset`=1 at a posedge: next state IDLE. Q, R, D, cnt, `quot`, `rem` all clear to 0. `ready`, `busy`, `div_by_zero` go to 0. This holds mid-RUN as well; the operation is abandoned.
- IDLE or DONE with `start`=1 and `divisor`!=0:
  - Q←`dividend`, D←`divisor`, R←0, cnt←0.
  - Next state RUN. `ready`/`div_by_zero` drop to 0 and `busy` rises on the same edge.
  - `quot`/`rem` hold their previous values.
- IDLE or DONE with `start`=1 and `divisor`==0:
  - Next state DONE directly.
  - `quot`←16'hFFFF, `rem`←`dividend[7:0]`, `div_by_zero`←1.
- IDLE or DONE with `start`=0: state and outputs hold.
- RUN, each posedge:
  - t = {R[7:0], Q[15]} (9 bits).
  - If t >= {1'b0, D}: R←t−D and the new bit is 1. Otherwise R←t and the new bit is 0.
  - Q←{Q[14:0], bit}, then cnt←cnt+1.
- On the iteration with cnt==15:
  - Next state DONE.
  - `quot` is set to the final shifted Q value, including this iteration's bit.
  - `rem` is set to the final R[7:0]. R[8] is guaranteed 0.
- `start` is ignored during RUN; there is no queueing.
- Result invariant: `quot`*`divisor`+`rem` == `dividend`, and `rem` < `divisor`.

## Timing
- All outputs are registered and change only on posedge `clk`.
- Latency, with the start-accept edge counted as edge 0:
  - Nonzero divisor: RUN iterations occur on edges 1–16, and `ready`=1 after edge 16.
  - Divisor 0: `ready`=1 after edge 0.
- `busy` is high from after edge 0 until after edge 16, for exactly 16 cycles.
- `ready` is a level signal. It stays high through DONE until the next accepted `start` or `reset`.
- Back-to-back operation: a `start` in the first DONE cycle is accepted. Throughput is one result per 17 cycles.
- `reset` and `start` in the same cycle: `reset` wins and the state goes to IDLE.
- Critical path: the 9-bit compare/subtract plus the next-state mux within one cycle.

## Test plan
- After reset, `start` with `dividend`=1000, `divisor`=7: `busy` high for 16 cycles, then `ready`=1 with `quot`=142, `rem`=6, `div_by_zero`=0.
- `dividend`=65535, `divisor`=255 → `quot`=257, `rem`=0. `dividend`=5, `divisor`=9 → `quot`=0, `rem`=5. `dividend`=200, `divisor`=1 → `quot`=200, `rem`=0.
- `dividend`=16'h1234, `divisor`=0 → one cycle later `ready`=1, `div_by_zero`=1, `quot`=16'hFFFF, `rem`=8'h34, and `busy` never asserts.
- `start` (1000/7), then assert `reset` on the 8th RUN cycle → next edge `busy`=0, `ready`=0, `quot`=0, `rem`=0. A following `start` with 100/10 → `quot`=10, `rem`=0 after 16 cycles.
- Pulse `start` with 50/3 during RUN of 1000/7 → the first result is unaffected (142, 6) and the second request is dropped. A `start` with 50/3 in the first DONE cycle → `quot`=16, `rem`=2 exactly 16 cycles later.
- Randomized dividend/divisor pairs with divisor nonzero, checked against the invariant `quot`*`divisor`+`rem`==`dividend` and `rem`<`divisor`.
